// File: rtl/cfg_bus_pkg.sv
// Shared types and constants for the tile configuration bus initiator.
package cfg_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      DRIVE = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int          CFG_ADDR_W   = 32;
   localparam int          CFG_DATA_W   = 32;
   localparam logic [31:0] CFG_END_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/config_stream_writer.sv
// Replays (address, data) records onto the config bus, holding config_en for
// HOLD_CYCLES and idling GAP_CYCLES between writes; END_ADDR closes the load.
module config_stream_writer
   import cfg_bus_pkg::*;
#(
   parameter int                ADDR_W      = CFG_ADDR_W,
   parameter int                DATA_W      = CFG_DATA_W,
   parameter int                HOLD_CYCLES = 2,
   parameter int                GAP_CYCLES  = 1,
   parameter logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(CFG_END_ADDR),
   parameter int                COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  in_addr,
   input  logic [DATA_W-1:0]  in_data,
   output logic [ADDR_W-1:0]  config_addr,
   output logic [DATA_W-1:0]  config_data,
   output logic               config_en,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] word_count,
   output logic [2:0]         fsm_state
);

   // Handshake: a record transfers on a rising edge where in_valid && in_ready;
   // in_ready is high only in WAIT and never depends on in_valid.
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic accept, is_end;

   logic [ADDR_W-1:0]  addr_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic [COUNT_W-1:0] count_nxt;
   logic en_nxt, ready_nxt, busy_nxt, done_nxt;

   assign accept    = in_ready && in_valid;
   assign is_end    = (in_addr == END_ADDR);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // One down-counter serves both the hold window and the gap window.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = WAIT;
         end
         WAIT: begin
            if (accept) begin
               if (is_end) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = DRIVE;
                  cnt_nxt   = HOLD_LOAD;
               end
            end
         end
         DRIVE: begin
            if (cnt == 4'd0) begin
               if (GAP_CYCLES == 0) begin
                  state_nxt = WAIT;
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = GAP_LOAD;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         GAP: begin
            if (cnt == 4'd0) state_nxt = WAIT;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      addr_nxt  = config_addr;
      data_nxt  = config_data;
      count_nxt = word_count;
      done_nxt  = done;
      if ((state == IDLE || state == DONE) && start) begin
         done_nxt  = 1'b0;
         count_nxt = '0;
      end
      if (accept) begin
         if (is_end) begin
            done_nxt = 1'b1;
         end else begin
            addr_nxt = in_addr;
            data_nxt = in_data;
            if (word_count != '1) count_nxt = word_count + 1'b1;
         end
      end
      en_nxt    = (state_nxt == DRIVE);
      ready_nxt = (state_nxt == WAIT);
      busy_nxt  = (state_nxt == WAIT) || (state_nxt == DRIVE) || (state_nxt == GAP);
   end

   // Async clear drops config_en immediately when a write is abandoned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         config_addr <= '0;
         config_data <= '0;
         config_en   <= 1'b0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         word_count  <= '0;
      end else begin
         config_addr <= addr_nxt;
         config_data <= data_nxt;
         config_en   <= en_nxt;
         in_ready    <= ready_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         word_count  <= count_nxt;
      end
   end

endmodule

// File: tb/tb_config_stream_writer.sv
// Directed bench: default timing instance (a) plus HOLD=1/GAP=0/COUNT_W=2 instance (b).
module tb_config_stream_writer;
   import cfg_bus_pkg::*;

   localparam logic [31:0] END = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic        start_a, valid_a, ready_a, en_a, busy_a, done_a;
   logic [31:0] addr_a, data_a, caddr_a, cdata_a;
   logic [15:0] wc_a;
   logic [2:0]  st_a;

   logic        start_b, valid_b, ready_b, en_b, busy_b, done_b;
   logic [31:0] addr_b, data_b, caddr_b, cdata_b;
   logic [1:0]  wc_b;
   logic [2:0]  st_b;

   always #5 clk = ~clk;

   config_stream_writer dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
      .in_addr(addr_a), .in_data(data_a), .config_addr(caddr_a), .config_data(cdata_a),
      .config_en(en_a), .busy(busy_a), .done(done_a), .word_count(wc_a), .fsm_state(st_a)
   );

   config_stream_writer #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .COUNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
      .in_addr(addr_b), .in_data(data_b), .config_addr(caddr_b), .config_data(cdata_b),
      .config_en(en_b), .busy(busy_b), .done(done_b), .word_count(wc_b), .fsm_state(st_b)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] en_pat;
      logic [7:0] rdy_pat;
      en_pat  = 8'b0011_0011;
      rdy_pat = 8'b1000_1000;
      reset = 1'b1;
      start_a = 0; valid_a = 0; addr_a = 0; data_a = 0;
      start_b = 0; valid_b = 0; addr_b = 0; data_b = 0;

      #1;
      check("rst_en",    en_a, 0);
      check("rst_ready", ready_a, 0);
      check("rst_busy",  busy_a, 0);
      check("rst_done",  done_a, 0);
      check("rst_wc",    wc_a, 0);
      check("rst_addr",  caddr_a, 0);
      check("rst_data",  cdata_a, 0);
      check("rst_state", st_a, IDLE);
      #20;
      @(negedge clk) reset = 1'b0;

      // in_valid in IDLE is never consumed
      valid_a = 1; addr_a = 32'h3; data_a = 32'h33;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("idle_ready", ready_a, 0);
         check("idle_en",    en_a, 0);
         check("idle_state", st_a, IDLE);
      end
      valid_a = 0;

      // single record then END
      start_a = 1; cyc(); start_a = 0;
      check("t1_ready", ready_a, 1);
      check("t1_busy",  busy_a, 1);
      valid_a = 1; addr_a = 32'h0; data_a = 32'h1;
      cyc();
      check("t1_en0",   en_a, 1);
      check("t1_addr",  caddr_a, 0);
      check("t1_data",  cdata_a, 1);
      check("t1_wc",    wc_a, 1);
      check("t1_rdy0",  ready_a, 0);
      addr_a = END; data_a = 32'h0;
      cyc();
      check("t1_en1",   en_a, 1);
      cyc();
      check("t1_gap",   en_a, 0);
      check("t1_hold",  cdata_a, 1);
      cyc();
      check("t1_rdy1",  ready_a, 1);
      cyc();
      valid_a = 0;
      check("t1_done",  done_a, 1);
      check("t1_wcend", wc_a, 1);
      check("t1_busy0", busy_a, 0);
      check("t1_addrk", caddr_a, 0);
      check("t1_datak", cdata_a, 1);
      check("t1_state", st_a, DONE);

      // back-to-back records, start pulsed during DRIVE
      start_a = 1; cyc(); start_a = 0;
      check("t2_clrd",  done_a, 0);
      check("t2_clrw",  wc_a, 0);
      valid_a = 1; addr_a = 32'h0; data_a = 32'h1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check($sformatf("t2_en%0d", i),  en_a, en_pat[i]);
         check($sformatf("t2_rdy%0d", i), ready_a, rdy_pat[i]);
         if (i == 0) begin data_a = 32'h8; start_a = 1; end
         if (i == 1) begin
            start_a = 0;
            check("t2_st_drive", st_a, DRIVE);
            check("t2_wc_keep",  wc_a, 1);
         end
         if (i == 4) begin
            check("t2_data8", cdata_a, 32'h8);
            addr_a = END;
         end
      end
      cyc();
      valid_a = 0;
      check("t2_done", done_a, 1);
      check("t2_wc",   wc_a, 2);
      check("t2_data", cdata_a, 32'h8);
      check("t2_en",   en_a, 0);

      // reset between edges in the 2nd DRIVE cycle
      start_a = 1; cyc(); start_a = 0;
      valid_a = 1; addr_a = 32'h5; data_a = 32'h9;
      cyc();
      valid_a = 0;
      cyc();
      check("rw_en_pre", en_a, 1);
      #2 reset = 1'b1;
      #1;
      check("rw_en",    en_a, 0);
      check("rw_addr",  caddr_a, 0);
      check("rw_data",  cdata_a, 0);
      check("rw_wc",    wc_a, 0);
      check("rw_busy",  busy_a, 0);
      check("rw_done",  done_a, 0);
      check("rw_ready", ready_a, 0);
      check("rw_state", st_a, IDLE);
      @(negedge clk) reset = 1'b0;

      // empty load
      start_a = 1; cyc(); start_a = 0;
      valid_a = 1; addr_a = END; data_a = 32'h77;
      cyc();
      valid_a = 0;
      check("el_done", done_a, 1);
      check("el_wc",   wc_a, 0);
      check("el_en",   en_a, 0);
      check("el_addr", caddr_a, 0);
      cyc();
      check("el_en2",  en_a, 0);

      // HOLD=1 GAP=0: one record every 2 cycles; 5 records saturate a 2-bit count
      start_b = 1; cyc(); start_b = 0;
      valid_b = 1; addr_b = 32'h1; data_b = 32'h1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check($sformatf("b_en%0d", i),  en_b, (i % 2 == 0));
         check($sformatf("b_rdy%0d", i), ready_b, (i % 2 == 1));
         if (i == 0) check("b_wc1", wc_b, 1);
         if (i == 4) check("b_wc3", wc_b, 3);
         if (i % 2 == 0) begin
            if (i == 8) begin
               addr_b = END;
            end else begin
               addr_b = 32'(i / 2 + 2);
               data_b = 32'(i / 2 + 2);
            end
         end
      end
      cyc();
      valid_b = 0;
      check("b_done", done_b, 1);
      check("b_wc",   wc_b, 3);
      check("b_data", cdata_b, 32'h5);
      check("b_addr", caddr_b, 32'h5);
      check("b_en",   en_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/config_stream_writer.md
Name: config_stream_writer

Overview:
- Initiator side of the tile configuration bus: drives config_addr / config_data / config_en into connection boxes, switch boxes and PEs.
- Consumes a stream of (address, data) configuration records over a valid/ready handshake.
- Replays each record onto the config bus with a guaranteed enable-hold window, so every config register captures the write on its clock edge.
- Sits between the bitstream source (host interface or test harness) and the array-level config fan-out.

Parameters:
- ADDR_W, 32, config address width.
- DATA_W, 32, config data width.
- HOLD_CYCLES, 2, cycles config_en stays high per record; legal range 1..15.
- GAP_CYCLES, 1, cycles config_en is low between records; legal range 0..15.
- END_ADDR, 32'hFFFF_FFFF, address value that marks end-of-bitstream; this record is never written to the bus.
- COUNT_W, 16, width of the word counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
- in_valid  in  1  record valid.
- in_ready  out  1  record accepted when in_valid && in_ready at a rising clk edge.
- in_addr  in  ADDR_W  record address.
- in_data  in  DATA_W  record data.
- config_addr  out  ADDR_W  config bus address.
- config_data  out  DATA_W  config bus data.
- config_en  out  1  config bus write enable.
- busy  out  1  high in WAIT, DRIVE and GAP.
- done  out  1  sticky; set when END_ADDR is accepted, cleared by the next start.
- word_count  out  COUNT_W  number of records written in the current load.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - config_en = 0 immediately, not at the next clock edge.
  - config_addr, config_data, word_count, busy, done and in_ready are all 0.
- All outputs are registered. in_ready is a registered state decode: it is 1 only in WAIT.
- IDLE / DONE:
  - in_ready = 0; in_valid is not consumed.
  - start goes to WAIT, clears done and clears word_count.
- WAIT: in_ready = 1. On handshake:
  - If in_addr == END_ADDR: go to DONE, set done, leave the config bus registers unchanged.
  - Otherwise: latch in_addr/in_data into config_addr/config_data, assert config_en, increment word_count (saturating at all-ones), go to DRIVE with hold_cnt = HOLD_CYCLES-1.
- DRIVE:
  - config_en = 1; config_addr and config_data are stable.
  - When hold_cnt == 0: if GAP_CYCLES == 0 go to WAIT, else go to GAP with gap_cnt = GAP_CYCLES-1.
  - Otherwise decrement hold_cnt.
- GAP:
  - config_en = 0; config_addr and config_data keep their last values.
  - When gap_cnt == 0 go to WAIT; otherwise decrement gap_cnt.
- Timing:
  - A handshake at edge N gives config_en = 1 for exactly HOLD_CYCLES cycles after N.
  - Next in_ready after that = N + HOLD_CYCLES + GAP_CYCLES, measured in cycles after N.
  - Maximum throughput is one record per HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Ignored inputs and boundary cases:
  - start while busy is ignored, with no restart.
  - in_valid in any state other than WAIT is ignored; the source must hold it.
  - Back-to-back valid records are each written exactly once; none are dropped or duplicated.
  - A load consisting only of END_ADDR gives done = 1, word_count = 0 and no config_en pulse.
  - Reset during DRIVE abandons the write; config_en falls asynchronously and the load must be restarted.

Decomposition:
- Shared package cfg_bus_pkg:
  - state enum {IDLE, WAIT, DRIVE, GAP, DONE}.
  - CFG_ADDR_W and CFG_DATA_W constants.
  - CFG_END_ADDR constant.
- No sub-module is required. The hold/gap down-counter is a single shared 4-bit counter inside this module.

Test Plan:
- Single record: start; record (addr 0, data 32'h1); then END_ADDR -> config_en high for exactly 2 cycles with config_addr 0 and config_data 1; then done = 1 and word_count = 1.
- Back-to-back records: in_valid held high with (0, 32'h1) then (0, 32'h8) -> two 2-cycle enable pulses separated by 1 low cycle; config_data holds 8 after the load; word_count = 2; in_ready high only in WAIT.
- GAP_CYCLES = 0 and HOLD_CYCLES = 1: 3 records -> config_en high, low, high, low, high; one record every 2 cycles.
- Ignored inputs: in_valid = 1 in IDLE for 5 cycles -> in_ready = 0 and config_en = 0 throughout; start during DRIVE -> no effect on state or word_count.
- Reset mid-write: assert reset in the 2nd DRIVE cycle, between clock edges -> config_en = 0 within the same cycle; all outputs 0; state IDLE.
- Empty load and counter saturation: END_ADDR only -> done = 1, word_count = 0, no enable. With COUNT_W = 2, 5 records -> word_count = 3.
